// File: rtl/blake2_digest_reader.sv
// Purpose: captures the Blake2 engine digest into a shadow register and serialises it as BUS_WIDTH words, truncated to digest_bytes.
// Latency: valid_out rises the cycle after digest_valid; a digest on the final transfer follows back-to-back.
// Backpressure: dout/valid_out/last_out are registered and held while ready_in=0. Optional DIGEST_OVERRUN_DETECT_EN adds the overrun port.
module blake2_digest_reader #(
  parameter int BUS_WIDTH    = 32,
  parameter int DIGEST_WIDTH = 512
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              digest_valid,
  input  logic [DIGEST_WIDTH-1:0]           digest,
  input  logic [$clog2(DIGEST_WIDTH/8):0]   digest_bytes,
  input  logic                              new_hash_request,
  output logic [BUS_WIDTH-1:0]              dout,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              last_out,
`ifdef DIGEST_OVERRUN_DETECT_EN
  output logic                              overrun,
`endif
  output logic                              busy
);

  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam int DIG_BYTES = DIGEST_WIDTH / 8;
  localparam int MAXW      = DIGEST_WIDTH / BUS_WIDTH;
  localparam int PTR_W     = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int NW_W      = $clog2(MAXW + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                             state_q, state_d;
  logic [MAXW-1:0][BUS_WIDTH-1:0]     shadow_q, shadow_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [NW_W-1:0]                    nwords_q, nwords_d;
  logic [BUS_WIDTH-1:0]               lastmask_q, lastmask_d;
  logic [BUS_WIDTH-1:0]               dout_q, dout_d;
  logic                               valid_q, valid_d;
  logic                               last_q, last_d;
`ifdef DIGEST_OVERRUN_DETECT_EN
  logic                               overrun_q, overrun_d;
`endif

  int                                 len_i;
  int                                 nw_i;
  int                                 rem_i;
  logic [NW_W-1:0]                    nwords_new;
  logic [BUS_WIDTH-1:0]               lastmask_new;
  logic                               xfer;
  logic                               capture;
  logic                               dv_ignored;

  // Decode the requested length into a word count and a byte mask for the final word.
  always_comb begin
    len_i = int'(digest_bytes);
    if (len_i == 0 || len_i > DIG_BYTES) begin
      len_i = DIG_BYTES;
    end
    nw_i       = (len_i + BUS_BYTES - 1) / BUS_BYTES;
    rem_i      = len_i % BUS_BYTES;
    nwords_new = NW_W'(nw_i);
    lastmask_new = '0;
    for (int b = 0; b < BUS_BYTES; b++) begin
      lastmask_new[8*b +: 8] = (rem_i == 0 || b < rem_i) ? 8'hFF : 8'h00;
    end
  end

  // Next-state logic; new_hash_request overrides capture and transfer alike.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    ptr_d      = ptr_q;
    nwords_d   = nwords_q;
    lastmask_d = lastmask_q;
    capture    = 1'b0;
    dv_ignored = 1'b0;
    xfer       = valid_q && ready_in;

    if (new_hash_request) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (digest_valid) begin
            capture = 1'b1;
          end
        end
        SEND: begin
          if (xfer && last_q) begin
            // Final word leaves: a coincident digest starts the next readout without a gap.
            if (digest_valid) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
              ptr_d   = '0;
            end
          end else begin
            if (xfer) begin
              ptr_d = ptr_q + 1'b1;
            end
            // The shadow is still in use, so this digest is dropped.
            dv_ignored = digest_valid;
          end
        end
        default: begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      endcase
    end

    if (capture) begin
      state_d    = SEND;
      shadow_d   = digest;
      ptr_d      = '0;
      nwords_d   = nwords_new;
      lastmask_d = lastmask_new;
    end
  end

  // Registered output word chosen from the post-update shadow and pointer so it is stable under backpressure.
  always_comb begin
    valid_d = (state_d == SEND);
    last_d  = valid_d && (int'(ptr_d) == int'(nwords_d) - 1);
    dout_d  = '0;
    if (valid_d) begin
      dout_d = shadow_d[ptr_d];
      if (last_d) begin
        dout_d = dout_d & lastmask_d;
      end
    end
  end

`ifdef DIGEST_OVERRUN_DETECT_EN
  // Sticky flag for a digest dropped while the shadow was busy.
  always_comb begin
    overrun_d = overrun_q;
    if (new_hash_request) begin
      overrun_d = 1'b0;
    end else if (dv_ignored) begin
      overrun_d = 1'b1;
    end
  end
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      ptr_q      <= '0;
      nwords_q   <= '0;
      lastmask_q <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
`ifdef DIGEST_OVERRUN_DETECT_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      ptr_q      <= ptr_d;
      nwords_q   <= nwords_d;
      lastmask_q <= lastmask_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
`ifdef DIGEST_OVERRUN_DETECT_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign busy      = (state_q == SEND);
`ifdef DIGEST_OVERRUN_DETECT_EN
  assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_blake2_digest_reader.sv
// Bench for blake2_digest_reader: directed test-plan scenarios followed by random traffic.
// Expected words come from a byte-level queue model of the truncated digest.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_blake2_digest_reader;

  localparam int BW = 32;
  localparam int DW = 512;
  localparam int BB = BW / 8;
  localparam int DB = DW / 8;

  logic              clk;
  logic              reset_n;
  logic              digest_valid;
  logic [DW-1:0]     digest;
  logic [6:0]        digest_bytes;
  logic              new_hash_request;
  logic [BW-1:0]     dout;
  logic              valid_out;
  logic              ready_in;
  logic              last_out;
  logic              busy;
`ifdef DIGEST_OVERRUN_DETECT_EN
  logic              overrun;
  logic              m_overrun;
`endif

  int                n_checks;
  int                n_fail;
  logic [BW-1:0]     mq[$];
  logic [DW-1:0]     a_dig;
  logic [DW-1:0]     b_dig;
  logic [DW-1:0]     r_dig;

  blake2_digest_reader #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .digest_valid     (digest_valid),
    .digest           (digest),
    .digest_bytes     (digest_bytes),
    .new_hash_request (new_hash_request),
    .dout             (dout),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .last_out         (last_out),
`ifdef DIGEST_OVERRUN_DETECT_EN
    .overrun          (overrun),
`endif
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected readout: effective length L bytes, split into words, bytes beyond L zeroed.
  task automatic model_load(input logic [DW-1:0] dg, input logic [6:0] nb);
    int L;
    int nw;
    logic [BW-1:0] w;
    L = int'(nb);
    if (L == 0 || L > DB) L = DB;
    nw = (L + BB - 1) / BB;
    mq.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < BB; b++) begin
        if (i * BB + b < L) w[8*b +: 8] = dg[8*(i*BB+b) +: 8];
      end
      mq.push_back(w);
    end
  endtask

  // Compare DUT against the model, apply one cycle of inputs, advance the model, and clock.
  task automatic step(input logic dv, input logic [DW-1:0] dg, input logic [6:0] nb,
                      input logic nhr, input logic rdy);
    bit  was_last;
    bit  xfer;
    check("valid_out", 64'(valid_out), 64'(mq.size() != 0));
    check("busy", 64'(busy), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("dout", 64'(dout), 64'(mq[0]));
      check("last_out", 64'(last_out), 64'(mq.size() == 1));
    end
`ifdef DIGEST_OVERRUN_DETECT_EN
    check("overrun", 64'(overrun), 64'(m_overrun));
`endif
    digest_valid     = dv;
    digest           = dg;
    digest_bytes     = nb;
    new_hash_request = nhr;
    ready_in         = rdy;

    if (!reset_n) begin
      mq.delete();
`ifdef DIGEST_OVERRUN_DETECT_EN
      m_overrun = 1'b0;
`endif
    end else if (nhr) begin
      mq.delete();
`ifdef DIGEST_OVERRUN_DETECT_EN
      m_overrun = 1'b0;
`endif
    end else if (mq.size() == 0) begin
      if (dv) model_load(dg, nb);
    end else begin
      xfer     = rdy;
      was_last = (mq.size() == 1);
      if (xfer) void'(mq.pop_front());
      if (xfer && was_last) begin
        if (dv) model_load(dg, nb);
      end else if (dv) begin
`ifdef DIGEST_OVERRUN_DETECT_EN
        m_overrun = 1'b1;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 7'd0, 1'b0, rdy);
  endtask

  task automatic run_until_size(input int k);
    for (int n = 0; n < 40 && mq.size() != k; n++) step(1'b0, '0, 7'd0, 1'b0, 1'b1);
    check("reach_word", 64'(mq.size()), 64'(k));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
`ifdef DIGEST_OVERRUN_DETECT_EN
    m_overrun = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      a_dig[32*i +: 32] = 32'hA000_0000 + i;
      b_dig[32*i +: 32] = 32'hB000_0000 + i;
    end
    reset_n = 1'b0;
    digest_valid = 1'b0;
    digest = '0;
    digest_bytes = '0;
    new_hash_request = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_last", 64'(last_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    idle_steps(2, 1'b1);

    // Full-length readout
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    check("full_nwords", 64'(mq.size()), 64'd16);
    idle_steps(18, 1'b1);

    // Truncation to 30 bytes, then zero meaning full length
    step(1'b1, a_dig, 7'd30, 1'b0, 1'b1);
    check("trunc_nwords", 64'(mq.size()), 64'd8);
    check("trunc_lastword", 64'(mq[7]), 64'h0000_0007);
    idle_steps(10, 1'b1);
    step(1'b1, a_dig, 7'd0, 1'b0, 1'b1);
    check("zero_nwords", 64'(mq.size()), 64'd16);
    idle_steps(18, 1'b1);

    // Backpressure on word 3
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    run_until_size(13);
    idle_steps(5, 1'b0);
    check("bp_hold", 64'(dout), 64'hA000_0003);
    idle_steps(15, 1'b1);

    // Abort on word 5 together with a digest
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    run_until_size(11);
    step(1'b1, b_dig, 7'd64, 1'b1, 1'b1);
    check("abort_valid", 64'(valid_out), 64'd0);
    idle_steps(3, 1'b1);

    // Back-to-back digests on the final transfer
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    run_until_size(1);
    step(1'b1, b_dig, 7'd64, 1'b0, 1'b1);
    check("b2b_first", 64'(dout), 64'hB000_0000);
    idle_steps(18, 1'b1);

    // Digest arriving mid-readout is dropped; A pattern continues
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    run_until_size(14);
    step(1'b1, b_dig, 7'd64, 1'b0, 1'b1);
`ifdef DIGEST_OVERRUN_DETECT_EN
    check("overrun_set", 64'(overrun), 64'd1);
`endif
    check("ovr_continue", 64'(dout), 64'hA000_0003);
    idle_steps(3, 1'b1);
    step(1'b0, '0, 7'd0, 1'b1, 1'b1);
`ifdef DIGEST_OVERRUN_DETECT_EN
    check("overrun_clr", 64'(overrun), 64'd0);
`endif
    idle_steps(2, 1'b1);

    // Reset mid-readout
    step(1'b1, a_dig, 7'd64, 1'b0, 1'b1);
    idle_steps(4, 1'b1);
    reset_n = 1'b0;
    step(1'b0, '0, 7'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    check("midrst_valid", 64'(valid_out), 64'd0);
    idle_steps(2, 1'b1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < DW / 32; i++) r_dig[32*i +: 32] = $urandom;
      step(($urandom % 8) == 0, r_dig, 7'($urandom_range(0, 127)),
           ($urandom % 64) == 0, ($urandom % 4) != 0);
    end
    idle_steps(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
